// File: rtl/color_bbox_if.sv
// Video-in / video-out / threshold / box-report bundle for color_bbox.
// slave is the color_bbox side; master is the source/sink side.
interface color_bbox_if #(
  parameter int unsigned H_ACT = 1280,
  parameter int unsigned V_ACT = 720
);
  localparam int XW = $clog2(H_ACT);
  localparam int YW = $clog2(V_ACT);

  logic [23:0]   lo_rgb;
  logic [23:0]   hi_rgb;
  logic          i_hsync;
  logic          i_vsync;
  logic          i_de;
  logic [7:0]    i_r;
  logic [7:0]    i_g;
  logic [7:0]    i_b;
  logic          o_hsync;
  logic          o_vsync;
  logic [7:0]    o_r;
  logic [7:0]    o_g;
  logic [7:0]    o_b;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] start_x;
  logic [XW-1:0] end_x;
  logic [YW-1:0] start_y;
  logic [YW-1:0] end_y;
  logic [23:0]   color;
  logic          box_valid;
  logic          frame_done;

  modport slave (
    input  lo_rgb, hi_rgb, i_hsync, i_vsync, i_de, i_r, i_g, i_b,
    output o_hsync, o_vsync, o_r, o_g, o_b, x, y,
    output start_x, end_x, start_y, end_y, color, box_valid, frame_done
  );

  modport master (
    output lo_rgb, hi_rgb, i_hsync, i_vsync, i_de, i_r, i_g, i_b,
    input  o_hsync, o_vsync, o_r, o_g, o_b, x, y,
    input  start_x, end_x, start_y, end_y, color, box_valid, frame_done
  );
endinterface

// File: rtl/color_bbox.sv
// Per-frame colour-window bounding-box finder with a 1-cycle video passthrough.
// Optional macro COLOR_BBOX_HOLD_EN: a frame with too few hits keeps the previous box.
module color_bbox #(
  parameter int unsigned H_ACT     = 1280,
  parameter int unsigned V_ACT     = 720,
  parameter int unsigned MIN_HITS  = 16,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst,
  color_bbox_if.slave bus
);
  localparam int XW = $clog2(H_ACT);
  localparam int YW = $clog2(V_ACT);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACT - 1);
  localparam logic [15:0]   HITS_MIN = 16'(MIN_HITS);

  typedef enum logic [0:0] {WAIT_SYNC, ACCUM} state_t;

  function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
    return (v == X_LAST) ? v : v + XW'(1);
  endfunction

  function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
    return (v == Y_LAST) ? v : v + YW'(1);
  endfunction

  function automatic logic [15:0] sat_inc_hits(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Coordinate 0 is reserved for "no box", so a valid box never reports it.
  function automatic logic [XW-1:0] clamp1_x(input logic [XW-1:0] v);
    return (v == '0) ? XW'(1) : v;
  endfunction

  function automatic logic [YW-1:0] clamp1_y(input logic [YW-1:0] v);
    return (v == '0) ? YW'(1) : v;
  endfunction

  function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  state_t        state_q, state_d;
  logic          vsync_q, de_q;
  logic          vs_rise, de_fall, hit;
  logic [XW-1:0] xc_q, xc_d;
  logic [YW-1:0] yc_q, yc_d;
  logic [23:0]   lo_q, lo_d, hi_q, hi_d;
  logic [XW-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [YW-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic [15:0]   hits_q, hits_d;
  logic [XW-1:0] start_x_q, start_x_d, end_x_q, end_x_d;
  logic [YW-1:0] start_y_q, start_y_d, end_y_q, end_y_d;
  logic [23:0]   color_q, color_d;
  logic          box_valid_q, box_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          o_hsync_q, o_vsync_q;
  logic [7:0]    o_r_q, o_g_q, o_b_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // Stage 0: edge detect, pixel coordinates, threshold shadows and match
  always_comb begin
    vs_rise = bus.i_vsync & ~vsync_q;
    de_fall = ~bus.i_de & de_q;

    xc_d = bus.i_de ? sat_inc_x(xc_q) : '0;

    yc_d = yc_q;
    if (vs_rise) begin
      yc_d = '0;
    end else if (de_fall) begin
      yc_d = sat_inc_y(yc_q);
    end

    lo_d = lo_q;
    hi_d = hi_q;
    if (vs_rise) begin
      lo_d = bus.lo_rgb;
      hi_d = bus.hi_rgb;
    end

    // The vs_rise pixel belongs to neither the closing nor the opening frame.
    hit = bus.i_de & ~vs_rise
        & in_range(bus.i_r, lo_q[23:16], hi_q[23:16])
        & in_range(bus.i_g, lo_q[15:8],  hi_q[15:8])
        & in_range(bus.i_b, lo_q[7:0],   hi_q[7:0]);
  end

  always_comb begin
    state_d      = state_q;
    min_x_d      = min_x_q;
    min_y_d      = min_y_q;
    max_x_d      = max_x_q;
    max_y_d      = max_y_q;
    hits_d       = hits_q;
    start_x_d    = start_x_q;
    start_y_d    = start_y_q;
    end_x_d      = end_x_q;
    end_y_d      = end_y_q;
    color_d      = color_q;
    box_valid_d  = box_valid_q;
    frame_done_d = 1'b0;

    case (state_q)
      WAIT_SYNC: begin
        if (vs_rise) state_d = ACCUM;
      end
      ACCUM: begin
        if (vs_rise) begin
          frame_done_d = 1'b1;
          if (hits_q >= HITS_MIN) begin
            start_x_d   = clamp1_x(min_x_q);
            start_y_d   = clamp1_y(min_y_q);
            end_x_d     = clamp1_x(max_x_q);
            end_y_d     = clamp1_y(max_y_q);
            color_d     = BOX_COLOR;
            box_valid_d = 1'b1;
          end else begin
`ifdef COLOR_BBOX_HOLD_EN
            start_x_d   = start_x_q;
            start_y_d   = start_y_q;
            end_x_d     = end_x_q;
            end_y_d     = end_y_q;
            color_d     = color_q;
            box_valid_d = box_valid_q;
`else
            start_x_d   = '0;
            start_y_d   = '0;
            end_x_d     = '0;
            end_y_d     = '0;
            color_d     = '0;
            box_valid_d = 1'b0;
`endif
          end
        end else if (hit) begin
          if (xc_q < min_x_q) min_x_d = xc_q;
          if (yc_q < min_y_q) min_y_d = yc_q;
          if (xc_q > max_x_q) max_x_d = xc_q;
          if (yc_q > max_y_q) max_y_d = yc_q;
          hits_d = sat_inc_hits(hits_q);
        end
      end
      default: state_d = WAIT_SYNC;
    endcase

    if (vs_rise) begin
      min_x_d = X_LAST;
      min_y_d = Y_LAST;
      max_x_d = '0;
      max_y_d = '0;
      hits_d  = '0;
    end
  end

  // Stage 1: registered state, published box and 1-cycle video passthrough
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_SYNC;
      vsync_q      <= 1'b0;
      de_q         <= 1'b0;
      xc_q         <= '0;
      yc_q         <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      min_x_q      <= X_LAST;
      min_y_q      <= Y_LAST;
      max_x_q      <= '0;
      max_y_q      <= '0;
      hits_q       <= '0;
      start_x_q    <= '0;
      start_y_q    <= '0;
      end_x_q      <= '0;
      end_y_q      <= '0;
      color_q      <= '0;
      box_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      o_hsync_q    <= 1'b0;
      o_vsync_q    <= 1'b0;
      o_r_q        <= '0;
      o_g_q        <= '0;
      o_b_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= bus.i_vsync;
      de_q         <= bus.i_de;
      xc_q         <= xc_d;
      yc_q         <= yc_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      min_x_q      <= min_x_d;
      min_y_q      <= min_y_d;
      max_x_q      <= max_x_d;
      max_y_q      <= max_y_d;
      hits_q       <= hits_d;
      start_x_q    <= start_x_d;
      start_y_q    <= start_y_d;
      end_x_q      <= end_x_d;
      end_y_q      <= end_y_d;
      color_q      <= color_d;
      box_valid_q  <= box_valid_d;
      frame_done_q <= frame_done_d;
      o_hsync_q    <= bus.i_hsync;
      o_vsync_q    <= bus.i_vsync;
      o_r_q        <= bus.i_r;
      o_g_q        <= bus.i_g;
      o_b_q        <= bus.i_b;
      x_q          <= xc_q;
      y_q          <= yc_q;
    end
  end

  assign bus.o_hsync    = o_hsync_q;
  assign bus.o_vsync    = o_vsync_q;
  assign bus.o_r        = o_r_q;
  assign bus.o_g        = o_g_q;
  assign bus.o_b        = o_b_q;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.start_x    = start_x_q;
  assign bus.start_y    = start_y_q;
  assign bus.end_x      = end_x_q;
  assign bus.end_y      = end_y_q;
  assign bus.color      = color_q;
  assign bus.box_valid  = box_valid_q;
  assign bus.frame_done = frame_done_q;
endmodule
